// File: rtl/yeokm1_pwm_audio.sv
// Single-voice tone synthesizer tile: phase-accumulator oscillator, 8-bit PWM audio and note display.
// Optional macro DIRECT_SAMPLE_EN makes wave=3 play uio_in; otherwise wave=3 is silent.
module yeokm1_pwm_audio #(
  parameter int PWM_BITS = 8,
  parameter int PHASE_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef struct packed {
    logic       mute;
    logic [1:0] vol;
    logic [1:0] wave;
    logic [2:0] note;
  } ctrl_t;

  ctrl_t ctrl;
  assign ctrl = ctrl_t'(ui_in);

  logic                muted;
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty;
  logic [PHASE_W-1:0]  phase;
  logic                pwm_q;
  logic [6:0]          seg_q;
  logic [PWM_BITS-1:0] p;
  logic [PWM_BITS-1:0] wave_val;
  logic [PWM_BITS-1:0] tri_up;

  assign muted  = ctrl.mute | ~ena;
  assign p      = phase[PHASE_W-1 -: PWM_BITS];
  assign tri_up = {p[PWM_BITS-2:0], 1'b0};

  function automatic logic [PHASE_W-1:0] note_inc(input logic [2:0] n);
    logic [PHASE_W-1:0] r;
    unique case (n)
      3'd0: r = PHASE_W'(439);
      3'd1: r = PHASE_W'(493);
      3'd2: r = PHASE_W'(553);
      3'd3: r = PHASE_W'(586);
      3'd4: r = PHASE_W'(658);
      3'd5: r = PHASE_W'(738);
      3'd6: r = PHASE_W'(829);
      default: r = PHASE_W'(878);
    endcase
    return r;
  endfunction

  // gfedcba, active-high; notes 0 and 7 are both C
  function automatic logic [6:0] seg_of(input logic [2:0] n);
    logic [6:0] r;
    unique case (n)
      3'd0: r = 7'h39;
      3'd1: r = 7'h5E;
      3'd2: r = 7'h79;
      3'd3: r = 7'h71;
      3'd4: r = 7'h3D;
      3'd5: r = 7'h77;
      3'd6: r = 7'h7C;
      default: r = 7'h39;
    endcase
    return r;
  endfunction

`ifndef DIRECT_SAMPLE_EN
  logic unused_uio;
  assign unused_uio = ^uio_in;
`endif

  always_comb begin
    wave_val = '0;
    unique case (ctrl.wave)
      2'd0: wave_val = {PWM_BITS{p[PWM_BITS-1]}};
      2'd1: wave_val = p;
      2'd2: wave_val = p[PWM_BITS-1] ? ~tri_up : tri_up;
`ifdef DIRECT_SAMPLE_EN
      default: wave_val = PWM_BITS'(uio_in);
`else
      default: wave_val = '0;
`endif
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= '0;
      duty  <= '0;
      pwm_q <= 1'b0;
      seg_q <= '0;
    end else begin
      cnt   <= cnt + 1'b1;
      pwm_q <= (cnt < duty);
      seg_q <= muted ? 7'h40 : seg_of(ctrl.note);
      // duty only changes at the period boundary so no PWM pulse is ever split
      if (cnt == '1) begin
        if (muted) begin
          phase <= '0;
          duty  <= '0;
        end else begin
          phase <= phase + note_inc(ctrl.note);
          duty  <= wave_val >> ctrl.vol;
        end
      end
    end
  end

  assign uo_out  = {pwm_q, seg_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_yeokm1_pwm_audio.sv
// Directed bench for yeokm1_pwm_audio: per-period PWM high counts and segment codes.
module tb_yeokm1_pwm_audio;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int failures = 0;

  yeokm1_pwm_audio dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #50 clk = ~clk;

`ifdef DIRECT_SAMPLE_EN
  localparam int D64 = 64;
  localparam int D31 = 31;
`else
  localparam int D64 = 0;
  localparam int D31 = 0;
`endif

  typedef struct {
    string      name;
    logic [7:0] ui;
    logic [7:0] uio;
    logic       en;
    int         seg;
    int         c1;
    int         c2;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Samples the 256 pwm_q values produced by one counter period.
  task automatic run_period(output int highs, output int seg0);
    highs = 0;
    seg0 = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 0) seg0 = int'(uo_out[6:0]);
      if (uo_out[7] === 1'b1) highs++;
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({name, "_rst_uo"}, int'(uo_out), 0);
    rst = 1'b0;
  endtask

  initial begin
    vec_t vt[14];
    int h, s, sum;

    // period 1 plays p=0; period 2 plays p = NOTE_INC>>8
    vt[0]  = '{"sq_c4",    8'h00, 8'h00, 1'b1, 'h39, 0,   0};
    vt[1]  = '{"saw_c4",   8'h08, 8'h00, 1'b1, 'h39, 0,   1};
    vt[2]  = '{"saw_a4",   8'h0D, 8'h00, 1'b1, 'h77, 0,   2};
    vt[3]  = '{"saw_c5_v1",8'h2F, 8'h00, 1'b1, 'h39, 0,   1};
    vt[4]  = '{"tri_c4",   8'h10, 8'h00, 1'b1, 'h39, 0,   2};
    vt[5]  = '{"tri_e4",   8'h12, 8'h00, 1'b1, 'h79, 0,   4};
    vt[6]  = '{"dir_40",   8'h18, 8'h40, 1'b1, 'h39, D64, D64};
    vt[7]  = '{"dir_ff_v3",8'h78, 8'hFF, 1'b1, 'h39, D31, D31};
    vt[8]  = '{"mute",     8'h80, 8'hFF, 1'b1, 'h40, 0,   0};
    vt[9]  = '{"ena0",     8'h08, 8'h00, 1'b0, 'h40, 0,   0};
    vt[10] = '{"sq_f4",    8'h03, 8'h00, 1'b1, 'h71, 0,   0};
    vt[11] = '{"saw_g4",   8'h0C, 8'h00, 1'b1, 'h3D, 0,   2};
    vt[12] = '{"saw_b4",   8'h0E, 8'h00, 1'b1, 'h7C, 0,   3};
    vt[13] = '{"saw_d4",   8'h09, 8'h00, 1'b1, 'h5E, 0,   1};

    repeat (3) @(negedge clk);
    chk("init_rst_uo", int'(uo_out), 0);
    chk("init_uio_out", int'(uio_out), 0);
    chk("init_uio_oe", int'(uio_oe), 0);

    foreach (vt[k]) begin
      ui_in = vt[k].ui; uio_in = vt[k].uio; ena = vt[k].en;
      do_reset(vt[k].name);
      run_period(h, s);
      chk({vt[k].name, "_p0"}, h, 0);
      chk({vt[k].name, "_seg"}, s, vt[k].seg);
      run_period(h, s);
      chk({vt[k].name, "_p1"}, h, vt[k].c1);
      run_period(h, s);
      chk({vt[k].name, "_p2"}, h, vt[k].c2);
      chk({vt[k].name, "_uio"}, int'({uio_out, uio_oe}), 0);
    end

    // square C4 sign flip: period n plays phase (n-1)*439, bit 15 first set at n=76
    ena = 1'b1; ui_in = 8'h00;
    do_reset("sq_long");
    sum = 0;
    for (int n = 0; n <= 76; n++) begin
      run_period(h, s);
      if (n >= 1 && n <= 75) sum += h;
      if (n == 76) chk("sq_long_p76", h, 255);
    end
    chk("sq_long_p1_75", sum, 0);

    // async reset mid-period while the output is high
    repeat (10) @(negedge clk);
    chk("midrst_before", int'(uo_out[7]), 1);
    #10 rst = 1'b1;
    #1 chk("midrst_async", int'(uo_out), 0);
    @(negedge clk);
    chk("midrst_edge", int'(uo_out), 0);
    rst = 1'b0;
    run_period(h, s);
    chk("midrst_p0", h, 0);

    // mute mid-period: current duty finishes, silence from the next wrap
    ui_in = 8'h12;
    do_reset("midmute");
    run_period(h, s);
    run_period(h, s);
    h = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); @(negedge clk);
      if (uo_out[7] === 1'b1) h++;
      if (i == 99) ui_in = 8'h80;
      if (i == 100) chk("midmute_seg", int'(uo_out[6:0]), 'h40);
    end
    chk("midmute_p2", h, 4);
    run_period(h, s);
    chk("midmute_p3", h, 0);

    // mute together with a note change: mute wins
    ui_in = 8'h0E;
    do_reset("mute_note");
    run_period(h, s);
    run_period(h, s);
    ui_in = 8'h8D;
    run_period(h, s);
    chk("mute_note_seg", s, 'h40);
    run_period(h, s);
    chk("mute_note_p3", h, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
